imm_encoder: RTL and testbench

//  Inverse of the immediate decoder: packs a 32-bit immediate plus register/opcode fields into
//  a 32-bit RV32 instruction word (I/S/B/U/J) and streams accepted words into program memory.

---
 rtl/imm_pkg.sv | 32 +++
 rtl/imm_pack.sv | 51 +++++
 rtl/imm_encoder.sv | 126 ++++++++++++
 tb/tb_imm_encoder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types for the immediate decoder/encoder pair: format select codes,
// encoder FSM states and the sign-extension legality helper.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } enc_state_t;

    localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

    // True when imm[31:lsb] are all copies of the sign bit, i.e. the value
    // survives truncation to an (lsb+1)-bit signed field.
    function automatic logic upper_uniform(input logic [31:0] imm, input int unsigned lsb);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if ((i >= int'(lsb)) && (imm[i] != imm[31])) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: scatters an immediate and register fields into an
// RV32 instruction word and flags immediates the chosen format cannot carry.
module imm_pack
    import imm_pkg::*;
(
    input  logic [2:0]  sel,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    output logic [31:0] instr,
    output logic        range_err,
    output logic        align_err,
    output logic        sel_err
);

    always_comb begin
        instr     = '0;
        range_err = 1'b0;
        align_err = 1'b0;
        sel_err   = 1'b0;
        case (sel)
            IMM_I: begin
                instr     = {imm[11:0], rs1, funct3, rd, opcode};
                range_err = !upper_uniform(imm, 11);
            end
            IMM_S: begin
                instr     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                range_err = !upper_uniform(imm, 11);
            end
            IMM_B: begin
                instr     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                range_err = !upper_uniform(imm, 12);
                align_err = imm[0];
            end
            IMM_U: begin
                instr     = {imm[31:12], rd, opcode};
                align_err = |imm[11:0];
            end
            IMM_J: begin
                instr     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                range_err = !upper_uniform(imm, 20);
                align_err = imm[0];
            end
            default: sel_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Streams encoded instructions into program memory with a one-cycle output
// register; illegal beats are dropped and tallied in sticky flags and a counter.
module imm_encoder
    import imm_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_imm_sel,
    input  logic [31:0]       in_imm,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [31:0]       pm_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_range,
    output logic              err_align,
    output logic              err_sel,
    output logic              overflow,
    output logic [7:0]        err_count
);

    enc_state_t        state;
    enc_state_t        state_nx;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       instr;
    logic              range_err;
    logic              align_err;
    logic              sel_err;
    logic              accept;
    logic              legal;
    logic              write;
    logic              at_last_addr;

    imm_pack u_pack (
        .sel       (in_imm_sel),
        .imm       (in_imm),
        .opcode    (in_opcode),
        .rd        (in_rd),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .funct3    (in_funct3),
        .instr     (instr),
        .range_err (range_err),
        .align_err (align_err),
        .sel_err   (sel_err)
    );

    assign in_ready     = (state == ST_RUN) && !start;
    assign accept       = in_valid && in_ready;
    assign legal        = !(range_err || align_err || sel_err);
    assign write        = accept && legal;
    assign at_last_addr = (addr == {ADDR_W{1'b1}});

    // An accepted in_last ends the load even when that beat itself is dropped.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN: begin
                if (start)
                    state_nx = ST_RUN;
                else if (accept && (in_last || (legal && at_last_addr)))
                    state_nx = ST_DONE;
            end
            ST_DONE: if (start) state_nx = ST_RUN;
            default: state_nx = ST_IDLE;
        endcase
    end

    // A write registered just before a restart still goes out at its old address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr      <= BASE_ADDR;
            pm_we     <= 1'b0;
            pm_addr   <= '0;
            pm_wdata  <= '0;
            err_range <= 1'b0;
            err_align <= 1'b0;
            err_sel   <= 1'b0;
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == ST_RUN);
            done  <= (state_nx == ST_DONE);
            pm_we <= write;
            if (write) begin
                pm_addr  <= addr;
                pm_wdata <= instr;
            end
            if (start) begin
                addr      <= BASE_ADDR;
                err_range <= 1'b0;
                err_align <= 1'b0;
                err_sel   <= 1'b0;
                overflow  <= 1'b0;
                err_count <= '0;
            end else begin
                if (write && !at_last_addr) addr <= addr + ADDR_W'(1);
                if (accept && !legal) begin
                    err_range <= err_range | range_err;
                    err_align <= err_align | align_err;
                    err_sel   <= err_sel | sel_err;
                    if (err_count != ERR_COUNT_MAX) err_count <= err_count + 8'd1;
                end
                if ((state == ST_DONE) && in_valid) overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and randomized checks of imm_encoder; random words are verified by
// decoding them back and comparing against arithmetic legality rules.
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_last;
    logic [2:0]  in_imm_sel;
    logic [31:0] in_imm;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;

    logic        in_ready, pm_we, busy, done, err_range, err_align, err_sel, overflow;
    logic [7:0]  pm_addr;
    logic [31:0] pm_wdata;
    logic [7:0]  err_count;

    logic        sm_in_ready, sm_pm_we, sm_busy, sm_done, sm_err_range, sm_err_align, sm_err_sel, sm_overflow;
    logic [1:0]  sm_pm_addr;
    logic [31:0] sm_pm_wdata;
    logic [7:0]  sm_err_count;

    int vectors;
    int miscompares;

    imm_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_imm_sel(in_imm_sel), .in_imm(in_imm), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata), .busy(busy), .done(done),
        .err_range(err_range), .err_align(err_align), .err_sel(err_sel),
        .overflow(overflow), .err_count(err_count)
    );

    imm_encoder #(.ADDR_W(2)) dutSmall (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(sm_in_ready),
        .in_last(in_last), .in_imm_sel(in_imm_sel), .in_imm(in_imm), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .pm_we(sm_pm_we), .pm_addr(sm_pm_addr), .pm_wdata(sm_pm_wdata), .busy(sm_busy), .done(sm_done),
        .err_range(sm_err_range), .err_align(sm_err_align), .err_sel(sm_err_sel),
        .overflow(sm_overflow), .err_count(sm_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic st, input logic valid, input logic last,
                                 input logic [2:0] sel, input logic [31:0] imm, input logic [6:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [2:0] f3);
        start      = st;
        in_valid   = valid;
        in_last    = last;
        in_imm_sel = sel;
        in_imm     = imm;
        in_opcode  = op;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_funct3  = f3;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Arithmetic view of what each format can hold.
    function automatic logic rangeBad(input logic [2:0] sel, input logic [31:0] imm);
        longint v;
        v = longint'($signed(imm));
        case (sel)
            3'd0, 3'd1: return (v < -2048) || (v > 2047);
            3'd2:       return (v < -4096) || (v > 4095);
            3'd4:       return (v < -1048576) || (v > 1048575);
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic alignBad(input logic [2:0] sel, input logic [31:0] imm);
        case (sel)
            3'd2, 3'd4: return (imm % 2) != 0;
            3'd3:       return (imm % 4096) != 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] legalImm(input logic [2:0] sel);
        int          v;
        logic [31:0] u;
        case (sel)
            3'd0, 3'd1: v = int'($urandom_range(0, 4095)) - 2048;
            3'd2:       v = (int'($urandom_range(0, 4095)) - 2048) * 2;
            3'd4:       v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
            default: begin
                u = 32'($urandom_range(0, 1048575));
                v = int'(u * 32'd4096);
            end
        endcase
        return 32'(v);
    endfunction

    // Standard RV32 immediate decoder, used to recover the immediate from written words.
    function automatic logic [31:0] decodeImm(input logic [31:0] i, input logic [2:0] sel);
        case (sel)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {i[31:12], 12'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    initial begin
        logic [2:0]  rsel;
        logic [31:0] rimm;
        logic [6:0]  rop;
        logic [4:0]  rrd, rrs1, rrs2;
        logic [2:0]  rf3;
        logic        rb, ab, sb, legal;
        int          expAddr, expCount, kind;
        logic        expRange, expAlign, expSel;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        applyStimulus(0, 0, 0, 3'd0, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0);
        repeat (3) @(negedge clk);
        checkOutput("rst_pm_we", 32'(pm_we), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
        checkOutput("rst_pm_addr", 32'(pm_addr), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // I-type with most negative 12-bit immediate, then B-type legal/misaligned, then I out of range
        applyStimulus(1, 0, 0, 3'd0, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0);
        @(negedge clk);
        applyStimulus(0, 1, 0, 3'd0, 32'hFFFFF800, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        #1;
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        checkOutput("t1_pm_we", 32'(pm_we), 32'd1);
        checkOutput("t1_pm_addr", 32'(pm_addr), 32'd0);
        checkOutput("t1_pm_wdata", pm_wdata, 32'h80000093);
        applyStimulus(0, 1, 0, 3'd2, 32'd8, 7'h63, 5'd0, 5'd2, 5'd3, 3'd1);
        @(negedge clk);
        checkOutput("t2_b_we", 32'(pm_we), 32'd1);
        checkOutput("t2_b_addr", 32'(pm_addr), 32'd1);
        checkOutput("t2_b_wdata", pm_wdata, 32'h00311463);
        applyStimulus(0, 1, 0, 3'd2, 32'd7, 7'h63, 5'd0, 5'd2, 5'd3, 3'd1);
        @(negedge clk);
        checkOutput("t2_align_we", 32'(pm_we), 32'd0);
        checkOutput("t2_err_align", 32'(err_align), 32'd1);
        checkOutput("t2_err_range_clear", 32'(err_range), 32'd0);
        applyStimulus(0, 1, 0, 3'd0, 32'h00000800, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        @(negedge clk);
        checkOutput("t2_range_we", 32'(pm_we), 32'd0);
        checkOutput("t2_err_range", 32'(err_range), 32'd1);
        checkOutput("t2_err_count", 32'(err_count), 32'd2);
        applyStimulus(0, 1, 0, 3'd0, 32'd5, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0);
        @(negedge clk);
        checkOutput("t2_addr_held", 32'(pm_addr), 32'd2);
        checkOutput("t2_wdata", pm_wdata, 32'h00500113);

        // Restart clears errors; illegal select dropped; in_last on third beat ends the load
        applyStimulus(1, 0, 0, 3'd0, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0);
        @(negedge clk);
        checkOutput("t4_cnt_clear", 32'(err_count), 32'd0);
        checkOutput("t4_range_clear", 32'(err_range), 32'd0);
        checkOutput("t4_align_clear", 32'(err_align), 32'd0);
        applyStimulus(0, 1, 0, 3'd0, 32'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0);
        @(negedge clk);
        checkOutput("t4_a_addr", 32'(pm_addr), 32'd0);
        checkOutput("t4_a_wdata", pm_wdata, 32'h00100193);
        applyStimulus(0, 1, 0, 3'd5, 32'd0, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0);
        @(negedge clk);
        checkOutput("t4_sel_we", 32'(pm_we), 32'd0);
        checkOutput("t4_err_sel", 32'(err_sel), 32'd1);
        applyStimulus(0, 1, 0, 3'd3, 32'h12345000, 7'h37, 5'd4, 5'd0, 5'd0, 3'd0);
        @(negedge clk);
        checkOutput("t4_u_addr", 32'(pm_addr), 32'd1);
        checkOutput("t4_u_wdata", pm_wdata, 32'h12345237);
        applyStimulus(0, 1, 1, 3'd4, 32'h00000800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0);
        @(negedge clk);
        checkOutput("t4_j_addr", 32'(pm_addr), 32'd2);
        checkOutput("t4_j_wdata", pm_wdata, 32'h001000EF);
        checkOutput("t4_done", 32'(done), 32'd1);
        checkOutput("t4_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(0, 1, 0, 3'd0, 32'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0);
        @(negedge clk);
        checkOutput("t4_overflow", 32'(overflow), 32'd1);
        checkOutput("t4_ovf_we", 32'(pm_we), 32'd0);
        applyStimulus(1, 0, 0, 3'd0, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0);
        @(negedge clk);
        checkOutput("t4_ovf_clear", 32'(overflow), 32'd0);
        checkOutput("t4_sel_clear", 32'(err_sel), 32'd0);
        checkOutput("t4_restart_busy", 32'(busy), 32'd1);
        applyStimulus(0, 1, 0, 3'd0, 32'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0);
        @(negedge clk);
        checkOutput("t4_restart_addr", 32'(pm_addr), 32'd0);
        checkOutput("t4_restart_we", 32'(pm_we), 32'd1);

        // Small address space: fills 0..3, stops, fifth beat flags overflow
        applyStimulus(1, 0, 0, 3'd0, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, 0, 3'd0, 32'(k), 7'h13, 5'(k), 5'd0, 5'd0, 3'd0);
            @(negedge clk);
            if (k < 4) begin
                checkOutput("t3_we", 32'(sm_pm_we), 32'd1);
                checkOutput("t3_addr", 32'(sm_pm_addr), 32'(k));
                checkOutput("t3_wdata", sm_pm_wdata, 32'(k) * 32'h00100000 + 32'(k) * 32'd128 + 32'h13);
            end else begin
                checkOutput("t3_ovf_we", 32'(sm_pm_we), 32'd0);
                checkOutput("t3_overflow", 32'(sm_overflow), 32'd1);
            end
            if (k == 3) begin
                checkOutput("t3_done", 32'(sm_done), 32'd1);
                checkOutput("t3_in_ready", 32'(sm_in_ready), 32'd0);
            end
        end

        // Reset asserted while a beat is offered mid-load
        applyStimulus(1, 0, 0, 3'd0, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0);
        @(negedge clk);
        applyStimulus(0, 1, 0, 3'd0, 32'd9, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t5_we", 32'(pm_we), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_in_ready", 32'(in_ready), 32'd0);
        checkOutput("t5_pm_wdata", pm_wdata, 32'd0);
        checkOutput("t5_sm_overflow", 32'(sm_overflow), 32'd0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 3'd0, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0);
        repeat (2) @(negedge clk);

        // Randomized loads of 200 beats each, mostly legal
        for (int chunk = 0; chunk < 6; chunk++) begin
            applyStimulus(1, 0, 0, 3'd0, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0);
            @(negedge clk);
            expAddr  = 0;
            expCount = 0;
            expRange = 1'b0;
            expAlign = 1'b0;
            expSel   = 1'b0;
            for (int i = 0; i < 200; i++) begin
                kind = int'($urandom_range(0, 9));
                if (kind < 8) begin
                    rsel = 3'($urandom_range(0, 4));
                    rimm = legalImm(rsel);
                end else if (kind == 8) begin
                    rsel = 3'($urandom_range(0, 4));
                    rimm = $urandom;
                end else begin
                    rsel = 3'($urandom_range(5, 7));
                    rimm = $urandom;
                end
                rop  = 7'($urandom_range(0, 127));
                rrd  = 5'($urandom_range(0, 31));
                rrs1 = 5'($urandom_range(0, 31));
                rrs2 = 5'($urandom_range(0, 31));
                rf3  = 3'($urandom_range(0, 7));
                applyStimulus(0, 1, (i == 199), rsel, rimm, rop, rrd, rrs1, rrs2, rf3);
                sb    = (rsel > 3'd4);
                rb    = rangeBad(rsel, rimm);
                ab    = alignBad(rsel, rimm);
                legal = !(rb || ab || sb);
                @(negedge clk);
                checkOutput("rnd_we", 32'(pm_we), 32'(legal));
                if (legal) begin
                    checkOutput("rnd_addr", 32'(pm_addr), 32'(expAddr));
                    checkOutput("rnd_imm", decodeImm(pm_wdata, rsel), rimm);
                    checkOutput("rnd_opcode", 32'(pm_wdata[6:0]), 32'(rop));
                    if (rsel == 3'd0 || rsel == 3'd3 || rsel == 3'd4)
                        checkOutput("rnd_rd", 32'(pm_wdata[11:7]), 32'(rrd));
                    if (rsel <= 3'd2) begin
                        checkOutput("rnd_rs1", 32'(pm_wdata[19:15]), 32'(rrs1));
                        checkOutput("rnd_f3", 32'(pm_wdata[14:12]), 32'(rf3));
                    end
                    if (rsel == 3'd1 || rsel == 3'd2)
                        checkOutput("rnd_rs2", 32'(pm_wdata[24:20]), 32'(rrs2));
                    expAddr++;
                end else begin
                    expRange = expRange | rb;
                    expAlign = expAlign | ab;
                    expSel   = expSel | sb;
                    if (expCount < 255) expCount++;
                end
            end
            applyStimulus(0, 0, 0, 3'd0, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0);
            checkOutput("rnd_done", 32'(done), 32'd1);
            checkOutput("rnd_err_range", 32'(err_range), 32'(expRange));
            checkOutput("rnd_err_align", 32'(err_align), 32'(expAlign));
            checkOutput("rnd_err_sel", 32'(err_sel), 32'(expSel));
            checkOutput("rnd_err_count", 32'(err_count), 32'(expCount));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
